// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path and the downstream scan-code
// decoder: receiver state encoding, frame length and common scan codes.
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Scan-code prefixes consumed by the decoder
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Odd parity holds when data plus parity bit contain an odd number of ones
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw asynchronous PS/2 line into the clk_i domain (2-flop
// synchronizer) and removes glitches: the filtered level only changes after
// the synchronized level has disagreed with it for FILTER_LEN consecutive
// cycles.
//
// Ports
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   line_i   : raw line (idle high)
//   filt_o   : synchronized, de-glitched level (resets high)
// ----------------------------------------------------------------------------
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic filt_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Lines idle high, so everything resets to 1 to avoid a false edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver. Conditions both raw lines, detects
// falling edges of the filtered clock, samples the filtered data on each
// edge and reassembles 11-bit frames into bytes. Good bytes are presented
// with a one-cycle valid pulse; bad parity, bad start/stop bits and
// inter-edge timeouts produce one-cycle error pulses instead.
//
// Ports
//   clk_i          : system clock
//   rst_n_i        : asynchronous active-low reset
//   ps2_clk_i      : raw PS/2 clock line
//   ps2_dat_i      : raw PS/2 data line
//   ps2_data_o     : last good byte, held until the next good frame
//   ps2_data_val_o : one-cycle pulse, ps2_data_o valid in the same cycle
//   parity_err_o   : one-cycle pulse, byte discarded on odd-parity failure
//   frame_err_o    : one-cycle pulse, bad start/stop bit or timeout
// ----------------------------------------------------------------------------
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] ps2_data_o,
    output logic       ps2_data_val_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX  = '1;

    logic clk_filt, dat_filt;
    logic fall;
    logic timeout;

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          clk_prev_q;
    logic [7:0]    data_q, data_d;
    logic          val_q, val_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .line_i  (ps2_clk_i),
        .filt_o  (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .line_i  (ps2_dat_i),
        .filt_o  (dat_filt)
    );

    assign fall = clk_prev_q & ~clk_filt;

    // An edge in the same cycle always beats the timeout
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        val_d     = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        // Inter-edge watchdog, saturating so it can never wrap back to a
        // small value and mask a stalled frame
        if (state_q == IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!dat_filt) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    // LSB arrives first, so shift right from the top
                    shift_d   = {dat_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_filt;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!dat_filt) begin
                        ferr_d = 1'b1;
                    end else if (ps2_parity_ok(shift_q, par_q)) begin
                        data_d = shift_q;
                        val_d  = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // timeout implies no edge this cycle, so the case above did nothing
        if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            clk_prev_q <= 1'b1;
            data_q     <= 8'h00;
            val_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            clk_prev_q <= clk_filt;
            data_q     <= data_d;
            val_q      <= val_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign ps2_data_o     = data_q;
    assign ps2_data_val_o = val_q;
    assign parity_err_o   = perr_q;
    assign frame_err_o    = ferr_q;

endmodule
